// File: rtl/bpu_pkg.sv
// bpu_pkg: shared types and counter helpers for the branch predictor.
package bpu_pkg;
  typedef enum logic [1:0] {
    UPD_NONE = 2'b00,
    UPD_BR   = 2'b01,
    UPD_JAL  = 2'b10,
    UPD_JALR = 2'b11
  } upd_type_e;
  typedef struct packed {
    logic valid;
    logic jump;
    logic ret;
  } bpu_meta_t;
  function automatic int unsigned cnt_init(input int unsigned w);
    return (1 << (w - 1)) - 1;
  endfunction
  function automatic int unsigned cnt_max(input int unsigned w);
    return (1 << w) - 1;
  endfunction
endpackage

// File: rtl/bpu_ras.sv
// bpu_ras: circular return-address stack with speculative (sp) and committed (cp) pointers.
module bpu_ras #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [XLEN-1:0] addr_i,
  input  logic            commit_push_i,
  input  logic            commit_pop_i,
  input  logic            stall_i,
  input  logic            flush_i,
  output logic [XLEN-1:0] top_o
);
  localparam int PW = $clog2(DEPTH);
  logic [XLEN-1:0] stack [DEPTH];
  logic [PW-1:0] sp_q, sp_d, cp_q, cp_d, wr_ptr;
  logic spec_push, spec_pop;
  assign spec_push = push_i && !stall_i && !flush_i;
  assign spec_pop  = pop_i && !stall_i && !flush_i;
  assign top_o     = stack[sp_q - PW'(1)];
  always_comb begin
    cp_d   = cp_q + PW'(commit_push_i) - PW'(commit_pop_i);
    sp_d   = flush_i ? cp_d : sp_q + PW'(spec_push) - PW'(spec_pop);
    wr_ptr = spec_pop ? sp_q - PW'(1) : sp_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sp_q <= '0;
      cp_q <= '0;
    end else begin
      sp_q <= sp_d;
      cp_q <= cp_d;
    end
  // push+pop in one cycle replaces the current top in place
  always_ff @(posedge clk)
    if (rst_n && spec_push) stack[wr_ptr] <= addr_i;
endmodule

// File: rtl/branch_pred_unit.sv
// branch_pred_unit: tagged BTB + saturating-counter BHT with perf counters.
// Define BPU_RAS_EN to add a return-address stack for jalr-return prediction.
module branch_pred_unit #(
  parameter int XLEN      = 32,
  parameter int ENTRIES   = 64,
  parameter int TAG_W     = 8,
  parameter int CNT_W     = 2,
  parameter int RAS_DEPTH = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] lk_pc_i,
  output logic            lk_hit_o,
  output logic            lk_taken_o,
  output logic [XLEN-1:0] lk_target_o,
  input  logic            upd_valid_i,
  input  logic [XLEN-1:0] upd_pc_i,
  input  logic [1:0]      upd_type_i,
  input  logic            upd_taken_i,
  input  logic [XLEN-1:0] upd_target_i,
  input  logic            upd_mispred_i,
  input  logic            ras_push_i,
  input  logic            ras_pop_i,
  input  logic [XLEN-1:0] ras_addr_i,
  input  logic            ras_commit_push_i,
  input  logic            ras_commit_pop_i,
  input  logic            pl_stall_i,
  input  logic            pl_flush_i,
  output logic [31:0]     br_cnt_o,
  output logic [31:0]     mis_cnt_o
);
  import bpu_pkg::*;
  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [CNT_W-1:0] CNT_WNT = CNT_W'(cnt_init(CNT_W));
  localparam logic [CNT_W-1:0] CNT_WT  = CNT_WNT + CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));
  bpu_meta_t meta_q [ENTRIES];
  bpu_meta_t meta_d [ENTRIES];
  logic [CNT_W-1:0] cnt_q [ENTRIES];
  logic [CNT_W-1:0] cnt_d [ENTRIES];
  logic [TAG_W-1:0] tag_mem [ENTRIES];
  logic [XLEN-1:0]  tgt_mem [ENTRIES];
  logic [31:0] br_cnt_q, br_cnt_d, mis_cnt_q, mis_cnt_d;
  logic [IDX_W-1:0] lk_idx, upd_idx;
  logic [TAG_W-1:0] lk_tag, upd_tag;
  logic [CNT_W-1:0] cur_cnt;
  logic [XLEN-1:0] ras_top;
  logic upd_en, upd_hit, upd_ret, tgt_we, lk_hit, lk_taken;
  upd_type_e upd_type;
  assign lk_idx   = lk_pc_i[IDX_W+1:2];
  assign lk_tag   = lk_pc_i[IDX_W+TAG_W+1:IDX_W+2];
  assign upd_idx  = upd_pc_i[IDX_W+1:2];
  assign upd_tag  = upd_pc_i[IDX_W+TAG_W+1:IDX_W+2];
  assign upd_type = upd_type_e'(upd_type_i);
  assign upd_en   = upd_valid_i && upd_type != UPD_NONE;
  assign upd_hit  = meta_q[upd_idx].valid && tag_mem[upd_idx] == upd_tag;
  assign cur_cnt  = cnt_q[upd_idx];
  assign tgt_we   = upd_en && (!upd_hit || upd_type != UPD_BR || upd_taken_i);
`ifdef BPU_RAS_EN
  assign upd_ret = upd_type == UPD_JALR && ras_commit_pop_i;
  bpu_ras #(.XLEN(XLEN), .DEPTH(RAS_DEPTH)) u_ras (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_i       (ras_push_i),
    .pop_i        (ras_pop_i),
    .addr_i       (ras_addr_i),
    .commit_push_i(ras_commit_push_i),
    .commit_pop_i (ras_commit_pop_i),
    .stall_i      (pl_stall_i),
    .flush_i      (pl_flush_i),
    .top_o        (ras_top)
  );
`else
  logic unused_ras;
  assign unused_ras = ^{ras_push_i, ras_pop_i, ras_addr_i, ras_commit_push_i, ras_commit_pop_i, pl_stall_i, pl_flush_i};
  assign upd_ret    = 1'b0;
  assign ras_top    = '0;
`endif
  logic unused_pc;
  assign unused_pc = ^upd_pc_i;
  // lookup reads pre-update state: no write-to-read bypass
  assign lk_hit      = meta_q[lk_idx].valid && tag_mem[lk_idx] == lk_tag;
  assign lk_taken    = lk_hit && (meta_q[lk_idx].jump || cnt_q[lk_idx][CNT_W-1]);
  assign lk_hit_o    = lk_hit;
  assign lk_taken_o  = lk_taken;
  assign lk_target_o = !lk_taken ? lk_pc_i + XLEN'(4)
                     : meta_q[lk_idx].jump && meta_q[lk_idx].ret ? ras_top : tgt_mem[lk_idx];
  assign br_cnt_o    = br_cnt_q;
  assign mis_cnt_o   = mis_cnt_q;
  always_comb begin
    meta_d    = meta_q;
    cnt_d     = cnt_q;
    br_cnt_d  = br_cnt_q + 32'(upd_en && ~&br_cnt_q);
    mis_cnt_d = mis_cnt_q + 32'(upd_en && upd_mispred_i && ~&mis_cnt_q);
    if (upd_en) begin
      meta_d[upd_idx] = '{valid: 1'b1,
                          jump: upd_type != UPD_BR || (upd_hit && meta_q[upd_idx].jump),
                          ret: upd_ret};
      cnt_d[upd_idx] = !upd_hit ? (upd_taken_i ? CNT_WT : CNT_WNT)
                     : upd_type != UPD_BR ? cur_cnt
                     : upd_taken_i ? (cur_cnt == CNT_MAX ? CNT_MAX : cur_cnt + CNT_W'(1))
                     : (cur_cnt == '0 ? '0 : cur_cnt - CNT_W'(1));
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        meta_q[i] <= '0;
        cnt_q[i]  <= CNT_WNT;
      end
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else begin
      meta_q    <= meta_d;
      cnt_q     <= cnt_d;
      br_cnt_q  <= br_cnt_d;
      mis_cnt_q <= mis_cnt_d;
    end
  // tag/target storage is plain RAM; valid bits gate its contents
  always_ff @(posedge clk)
    if (rst_n && upd_en) begin
      tag_mem[upd_idx] <= upd_tag;
      if (tgt_we) tgt_mem[upd_idx] <= upd_target_i;
    end
endmodule

// File: tb/tb_branch_pred_unit.sv
// tb_branch_pred_unit: directed table, corner sequences and random traffic vs a behavioural model.
module tb_branch_pred_unit;
  localparam int ENTRIES = 64;
  localparam int TAG_W   = 8;
  localparam int CNT_W   = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] lk_pc_i, upd_pc_i, upd_target_i, ras_addr_i, lk_target_o, br_cnt_o, mis_cnt_o;
  logic lk_hit_o, lk_taken_o, upd_valid_i, upd_taken_i, upd_mispred_i;
  logic [1:0] upd_type_i;
  logic ras_push_i, ras_pop_i, ras_commit_push_i, ras_commit_pop_i, pl_stall_i, pl_flush_i;
  int checks = 0;
  int failures = 0;

  branch_pred_unit dut (
    .clk(clk), .rst_n(rst_n), .lk_pc_i(lk_pc_i), .lk_hit_o(lk_hit_o), .lk_taken_o(lk_taken_o),
    .lk_target_o(lk_target_o), .upd_valid_i(upd_valid_i), .upd_pc_i(upd_pc_i), .upd_type_i(upd_type_i),
    .upd_taken_i(upd_taken_i), .upd_target_i(upd_target_i), .upd_mispred_i(upd_mispred_i),
    .ras_push_i(ras_push_i), .ras_pop_i(ras_pop_i), .ras_addr_i(ras_addr_i),
    .ras_commit_push_i(ras_commit_push_i), .ras_commit_pop_i(ras_commit_pop_i),
    .pl_stall_i(pl_stall_i), .pl_flush_i(pl_flush_i), .br_cnt_o(br_cnt_o), .mis_cnt_o(mis_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // behavioural model: one record per index, counter kept as an integer
  bit          m_valid [ENTRIES];
  int unsigned m_tag   [ENTRIES];
  bit          m_jump  [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  int          m_cnt   [ENTRIES];
  int unsigned m_br, m_mis;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc / 4) % ENTRIES);
  endfunction
  function automatic int unsigned tag_of(input logic [31:0] pc);
    return (pc / (4 * ENTRIES)) % (1 << TAG_W);
  endfunction
  function automatic void model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 0;
      m_cnt[i] = (1 << (CNT_W - 1)) - 1;
    end
    m_br = 0;
    m_mis = 0;
  endfunction
  function automatic void model_lookup(input logic [31:0] pc, output logic hit, output logic tk, output logic [31:0] tgt);
    int i = idx_of(pc);
    hit = m_valid[i] && m_tag[i] == tag_of(pc);
    tk = hit && (m_jump[i] || m_cnt[i] >= (1 << (CNT_W - 1)));
    tgt = tk ? m_tgt[i] : pc + 32'd4;
  endfunction
  function automatic void model_update(input logic [1:0] ty, input logic [31:0] pc, input logic tk,
                                       input logic [31:0] tgt, input logic mis);
    int i = idx_of(pc);
    if (ty == 2'b00) return;
    m_br++;
    if (mis) m_mis++;
    if (m_valid[i] && m_tag[i] == tag_of(pc)) begin
      if (ty == 2'b01) begin
        m_cnt[i] = tk ? ((m_cnt[i] + 1 > (1 << CNT_W) - 1) ? (1 << CNT_W) - 1 : m_cnt[i] + 1)
                      : ((m_cnt[i] == 0) ? 0 : m_cnt[i] - 1);
        if (tk) m_tgt[i] = tgt;
      end else begin
        m_tgt[i] = tgt;
        m_jump[i] = 1;
      end
    end else begin
      m_valid[i] = 1;
      m_tag[i] = tag_of(pc);
      m_jump[i] = ty != 2'b01;
      m_tgt[i] = tgt;
      m_cnt[i] = tk ? (1 << (CNT_W - 1)) : (1 << (CNT_W - 1)) - 1;
    end
  endfunction

  task automatic drive(input logic v, input logic [1:0] ty, input logic [31:0] pc, input logic tk,
                       input logic [31:0] tgt, input logic mis);
    upd_valid_i = v;
    upd_type_i = ty;
    upd_pc_i = pc;
    upd_taken_i = tk;
    upd_target_i = tgt;
    upd_mispred_i = mis;
  endtask

`ifdef BPU_RAS_EN
  task automatic ras_op(input logic push, input logic pop, input logic flush, input logic stall, input logic [31:0] a);
    ras_push_i = push;
    ras_pop_i = pop;
    pl_flush_i = flush;
    pl_stall_i = stall;
    ras_addr_i = a;
    @(posedge clk);
    #1;
    ras_push_i = 0;
    ras_pop_i = 0;
    pl_flush_i = 0;
    pl_stall_i = 0;
  endtask
  task automatic ras_chk(input string name, input logic [31:0] exp);
    #1 chk(name, lk_target_o, exp);
  endtask
`endif

  typedef struct {
    logic [1:0]  ty;
    logic [31:0] pc;
    logic        tk;
    logic [31:0] tgt;
    logic        mis;
    logic [31:0] lk;
    logic        e_hit;
    logic        e_tk;
    logic [31:0] e_tgt;
  } vec_t;
  vec_t tv [15];

  initial begin
    logic h, t;
    logic [31:0] g;
    tv[0]  = '{2'd1, 32'h100, 1'b1, 32'h80,   1'b1, 32'h100,      1'b1, 1'b1, 32'h80};
    tv[1]  = '{2'd1, 32'h100, 1'b1, 32'h80,   1'b0, 32'h100,      1'b1, 1'b1, 32'h80};
    tv[2]  = '{2'd1, 32'h100, 1'b1, 32'h80,   1'b0, 32'h100,      1'b1, 1'b1, 32'h80};
    tv[3]  = '{2'd1, 32'h100, 1'b0, 32'h104,  1'b1, 32'h100,      1'b1, 1'b1, 32'h80};
    tv[4]  = '{2'd1, 32'h100, 1'b0, 32'h104,  1'b1, 32'h100,      1'b1, 1'b0, 32'h104};
    tv[5]  = '{2'd1, 32'h100, 1'b0, 32'h104,  1'b1, 32'h100,      1'b1, 1'b0, 32'h104};
    tv[6]  = '{2'd1, 32'h100, 1'b0, 32'h104,  1'b0, 32'h100,      1'b1, 1'b0, 32'h104};
    tv[7]  = '{2'd1, 32'h100, 1'b1, 32'h90,   1'b1, 32'h100,      1'b1, 1'b0, 32'h104};
    tv[8]  = '{2'd1, 32'h100, 1'b1, 32'h90,   1'b1, 32'h100,      1'b1, 1'b1, 32'h90};
    tv[9]  = '{2'd1, 32'h200, 1'b1, 32'h40,   1'b1, 32'h100,      1'b0, 1'b0, 32'h104};
    tv[10] = '{2'd0, 32'h200, 1'b1, 32'h44,   1'b1, 32'h200,      1'b1, 1'b1, 32'h40};
    tv[11] = '{2'd2, 32'h310, 1'b1, 32'h1000, 1'b1, 32'h310,      1'b1, 1'b1, 32'h1000};
    tv[12] = '{2'd3, 32'h314, 1'b1, 32'h2000, 1'b0, 32'h314,      1'b1, 1'b1, 32'h2000};
    tv[13] = '{2'd0, 32'h0,   1'b0, 32'h0,    1'b0, 32'hFFFFFFFC, 1'b0, 1'b0, 32'h0};
    tv[14] = '{2'd0, 32'h0,   1'b0, 32'h0,    1'b0, 32'h600,      1'b0, 1'b0, 32'h604};
    drive(0, 2'd0, 0, 0, 0, 0);
    {ras_push_i, ras_pop_i, ras_commit_push_i, ras_commit_pop_i, pl_stall_i, pl_flush_i} = '0;
    ras_addr_i = '0;
    lk_pc_i = 32'h100;
    model_reset();
    #12;
    chk("rst_hit", lk_hit_o, 0);
    chk("rst_taken", lk_taken_o, 0);
    chk("rst_target", lk_target_o, 32'h104);
    chk("rst_br", br_cnt_o, 0);
    chk("rst_mis", mis_cnt_o, 0);
    @(negedge clk) rst_n = 1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 15; k++) begin
      drive(1, tv[k].ty, tv[k].pc, tv[k].tk, tv[k].tgt, tv[k].mis);
      lk_pc_i = tv[k].lk;
      @(posedge clk);
      model_update(tv[k].ty, tv[k].pc, tv[k].tk, tv[k].tgt, tv[k].mis);
      #1 upd_valid_i = 0;
      #1;
      chk($sformatf("v%0d_hit", k), lk_hit_o, tv[k].e_hit);
      chk($sformatf("v%0d_taken", k), lk_taken_o, tv[k].e_tk);
      chk($sformatf("v%0d_target", k), lk_target_o, tv[k].e_tgt);
      chk($sformatf("v%0d_br", k), br_cnt_o, m_br);
      chk($sformatf("v%0d_mis", k), mis_cnt_o, m_mis);
    end
    // same-cycle update and lookup of one entry
    drive(1, 2'd2, 32'h200, 1, 32'h500, 0);
    lk_pc_i = 32'h200;
    #1 chk("same_cycle_old", lk_target_o, 32'h40);
    @(posedge clk);
    model_update(2'd2, 32'h200, 1, 32'h500, 0);
    #1 upd_valid_i = 0;
    #1 chk("same_cycle_new", lk_target_o, 32'h500);
    // asynchronous reset between edges, with an update held across an edge
    rst_n = 0;
    drive(1, 2'd1, 32'h200, 1, 32'h60, 1);
    #1;
    chk("arst_hit", lk_hit_o, 0);
    chk("arst_target", lk_target_o, 32'h204);
    chk("arst_br", br_cnt_o, 0);
    @(posedge clk);
    #1 upd_valid_i = 0;
    model_reset();
    @(negedge clk) rst_n = 1;
    #1;
    chk("arst_abort_hit", lk_hit_o, 0);
    chk("arst_abort_br", br_cnt_o, 0);
`ifdef BPU_RAS_EN
    @(posedge clk);
    #1;
    drive(1, 2'd3, 32'h400, 1, 32'h999, 0);
    ras_commit_push_i = 1;
    ras_commit_pop_i = 1;
    lk_pc_i = 32'h400;
    @(posedge clk);
    #1 upd_valid_i = 0;
    ras_commit_push_i = 0;
    ras_commit_pop_i = 0;
    ras_op(1, 0, 0, 0, 32'h204);
    ras_op(1, 0, 0, 0, 32'h304);
    ras_chk("ras_push2", 32'h304);
    ras_op(0, 1, 0, 0, 0);
    ras_chk("ras_pop", 32'h204);
    ras_op(0, 0, 1, 0, 0);
    ras_op(1, 0, 0, 0, 32'h111);
    ras_chk("ras_flush", 32'h111);
    ras_op(1, 0, 0, 1, 32'h222);
    ras_chk("ras_stall", 32'h111);
    ras_op(1, 1, 0, 0, 32'h333);
    ras_chk("ras_pushpop", 32'h333);
    for (int k = 1; k <= 9; k++) ras_op(1, 0, 0, 0, 32'h1000 + 4 * k);
    ras_chk("ras_wrap_top", 32'h1024);
    ras_op(0, 1, 0, 0, 0);
    ras_chk("ras_wrap_pop1", 32'h1020);
    ras_op(0, 1, 0, 0, 0);
    ras_chk("ras_wrap_pop2", 32'h101C);
    rst_n = 0;
    model_reset();
    @(negedge clk) rst_n = 1;
`endif
    @(posedge clk);
    #1;
    for (int n = 0; n < 3000; n++) begin
      logic [1:0] ty;
      logic [31:0] pc;
      ty = 2'($urandom_range(0, 3));
      pc = 32'((($urandom_range(0, 2) * ENTRIES) + $urandom_range(0, 7)) * 4);
      drive($urandom_range(0, 3) != 0, ty, pc, ty >= 2'd2 ? 1'b1 : 1'($urandom),
            $urandom & 32'hFFFF_FFFC, 1'($urandom));
      lk_pc_i = ($urandom_range(0, 7) == 0) ? $urandom
              : 32'((($urandom_range(0, 2) * ENTRIES) + $urandom_range(0, 7)) * 4);
      #1;
      model_lookup(lk_pc_i, h, t, g);
      chk("rnd_hit", lk_hit_o, h);
      chk("rnd_taken", lk_taken_o, t);
      chk("rnd_target", lk_target_o, g);
      chk("rnd_br", br_cnt_o, m_br);
      chk("rnd_mis", mis_cnt_o, m_mis);
      @(posedge clk);
      if (upd_valid_i) model_update(upd_type_i, upd_pc_i, upd_taken_i, upd_target_i, upd_mispred_i);
      #1;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
